// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: register-file model of the RTC behind the multiplexed AD/CS/RD/WR bus.
// Synchronizes the bus, decodes address/data phases, commits writes and answers reads.
module rtc_bus_responder #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ad_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic [7:0] addr_q,
  output logic       wr_pulse,
  output logic       proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [11:0] IDLE_BUS = 12'hF00;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_DATA,
    ERR
  } state_e;

  logic [11:0] syncMeta_q;
  logic [11:0] syncBus_q;
  logic [1:0]  prevStrobe_q;
  logic [1:0]  flushVld_q;
  logic        armed_q;
  state_e      state_q;
  state_e      state_d;
  logic [7:0]  mem_q [DEPTH];
  logic [7:0]  dataOut_q;
  logic        dataOe_q;
  logic        wrPulse_q;
  logic        protoErr_q;

  logic       syncAd;
  logic       syncCs;
  logic       syncRd;
  logic       syncWr;
  logic [7:0] syncData;
  logic       wrFall;
  logic       wrRise;
  logic       rdFall;
  logic       addrInRange;
  logic [7:0] memRdData;
  logic       latchAddr;
  logic       commitWrite;

  assign {syncAd, syncCs, syncRd, syncWr, syncData} = syncBus_q;

  assign wrFall      = prevStrobe_q[0] & ~syncWr;
  assign wrRise      = ~prevStrobe_q[0] & syncWr;
  assign rdFall      = prevStrobe_q[1] & ~syncRd;
  assign addrInRange = ({24'd0, addr_q} < 32'(DEPTH));
  assign memRdData   = addrInRange ? mem_q[addr_q[AW-1:0]] : 8'h00;

  assign data_out  = dataOut_q;
  assign data_oe   = dataOe_q;
  assign wr_pulse  = wrPulse_q;
  assign proto_err = protoErr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncMeta_q   <= IDLE_BUS;
      syncBus_q    <= IDLE_BUS;
      prevStrobe_q <= 2'b11;
    end else begin
      syncMeta_q   <= {ad_n, cs_n, rd_n, wr_n, data_in};
      syncBus_q    <= syncMeta_q;
      prevStrobe_q <= {syncRd, syncWr};
    end
  end

  always_comb begin
    state_d     = state_q;
    latchAddr   = 1'b0;
    commitWrite = 1'b0;
    if (!syncCs && !syncRd && !syncWr) begin
      state_d = ERR;
    end else begin
      case (state_q)
        IDLE: begin
          if (armed_q && !syncCs) begin
            if (wrFall) begin
              state_d = syncAd ? WR_DATA : WR_ADDR;
            end else if (rdFall && syncAd) begin
              state_d = RD_DATA;
            end
          end
        end
        WR_ADDR: begin
          if (syncCs) begin
            state_d = IDLE;
          end else if (wrRise) begin
            latchAddr = 1'b1;
            state_d   = IDLE;
          end
        end
        WR_DATA: begin
          if (syncCs) begin
            state_d = IDLE;
          end else if (wrRise) begin
            commitWrite = addrInRange;
            state_d     = IDLE;
          end
        end
        RD_DATA: begin
          if (syncCs || syncRd) begin
            state_d = IDLE;
          end
        end
        ERR: begin
          if (syncCs && syncRd && syncWr) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge detection stays disarmed until the synchronizer has flushed and both strobes read high,
  // so a strobe held low across reset release is ignored until it cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      flushVld_q <= 2'b00;
      armed_q    <= 1'b0;
      addr_q     <= 8'h00;
      dataOut_q  <= 8'h00;
      dataOe_q   <= 1'b0;
      wrPulse_q  <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flushVld_q <= {flushVld_q[0], 1'b1};
      armed_q    <= armed_q | (flushVld_q[1] & syncRd & syncWr);
      if (latchAddr) begin
        addr_q <= syncData;
      end
      if (state_d == RD_DATA && state_q != RD_DATA) begin
        dataOut_q <= memRdData;
      end
      dataOe_q   <= (state_d == RD_DATA);
      wrPulse_q  <= commitWrite;
      protoErr_q <= protoErr_q | (state_d == ERR && state_q != ERR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (commitWrite) begin
      mem_q[addr_q[AW-1:0]] <= syncData;
    end
  end

endmodule
